// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks: divider FSM state
// encoding and a helper that sizes the iteration counter from the operand width.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_nr_divider_step.sv
// One non-restoring iteration: shift the quotient MSB into the partial remainder,
// then add or subtract |divisor| through an explicit ripple-carry chain.
module nr_div_step #(
    parameter int WIDTH = 4
) (
    input  logic signed [WIDTH:0]   p,
    input  logic                    q_msb,
    input  logic        [WIDTH-1:0] abs_b,
    output logic signed [WIDTH:0]   p_new,
    output logic                    q_bit
);

    logic             sub;
    logic [WIDTH:0]   a;
    logic [WIDTH:0]   b;
    logic [WIDTH:0]   s;
    logic [WIDTH:0]   c;

    // Non-negative remainder subtracts; subtraction is invert-and-carry-in.
    assign sub  = ~p[WIDTH];
    assign a    = {p[WIDTH-1:0], q_msb};
    assign b    = {1'b0, abs_b} ^ {(WIDTH+1){sub}};
    assign c[0] = sub;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
        assign s[i] = a[i] ^ b[i] ^ c[i];
        if (i < WIDTH) begin : g_carry
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign p_new = signed'(s);
    assign q_bit = ~s[WIDTH];

endmodule

// File: rtl/seq_nr_divider.sv
// Sequential signed radix-2 non-restoring divider with start/busy/done handshake.
// Works on magnitudes, one quotient bit per clock, then restores signs in FIX.
module seq_nr_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] dividend,
    input  logic signed [WIDTH-1:0] divisor,
    output logic signed [WIDTH-1:0] quotient,
    output logic signed [WIDTH-1:0] remainder,
    output logic                    busy,
    output logic                    done,
    output logic                    div_by_zero,
    output logic                    overflow
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t                  state;
    state_t                  state_nxt;
    logic        [CNT_W-1:0] cnt;
    logic signed [WIDTH:0]   p;
    logic        [WIDTH-1:0] q;
    logic        [WIDTH-1:0] abs_b;
    logic signed [WIDTH-1:0] dividend_r;
    logic                    sign_a;
    logic                    sign_b;
    logic                    zero_r;
    logic                    ovf_r;

    logic                    accept;
    logic signed [WIDTH:0]   p_step;
    logic                    q_bit;
    logic signed [WIDTH:0]   p_fix;
    logic signed [WIDTH-1:0] q_res;
    logic signed [WIDTH-1:0] r_res;

    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] u;
        u = v;
        return v[WIDTH-1] ? (~u + WIDTH'(1)) : u;
    endfunction

    function automatic logic signed [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                          input logic             neg);
        return neg ? signed'(~mag + WIDTH'(1)) : signed'(mag);
    endfunction

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign busy   = (state == CALC) || (state == FIX);
    assign done   = (state == DONE);

    nr_div_step #(.WIDTH(WIDTH)) u_step (
        .p     (p),
        .q_msb (q[WIDTH-1]),
        .abs_b (abs_b),
        .p_new (p_step),
        .q_bit (q_bit)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = start ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Final correction: a negative partial remainder is restored once, then the
    // magnitudes get their signs; /0 and the single overflow pair override.
    always_comb begin
        p_fix = p[WIDTH] ? (p + signed'({1'b0, abs_b})) : p;
        q_res = apply_sign(q, sign_a ^ sign_b);
        r_res = apply_sign(p_fix[WIDTH-1:0], sign_a);
        if (zero_r) begin
            q_res = '1;
            r_res = dividend_r;
        end else if (ovf_r) begin
            q_res = signed'({1'b1, {(WIDTH-1){1'b0}}});
            r_res = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            p           <= '0;
            q           <= '0;
            abs_b       <= '0;
            dividend_r  <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt        <= CNT_W'(WIDTH - 1);
                p          <= '0;
                q          <= abs_val(dividend);
                abs_b      <= abs_val(divisor);
                dividend_r <= dividend;
                sign_a     <= dividend[WIDTH-1];
                sign_b     <= divisor[WIDTH-1];
                zero_r     <= (divisor == '0);
                ovf_r      <= dividend[WIDTH-1] && (dividend[WIDTH-2:0] == '0) && (&divisor);
            end else if (state == CALC) begin
                cnt <= cnt - CNT_W'(1);
                p   <= p_step;
                q   <= {q[WIDTH-2:0], q_bit};
            end else if (state == FIX) begin
                quotient    <= q_res;
                remainder   <= r_res;
                div_by_zero <= zero_r;
                overflow    <= ovf_r;
            end
        end
    end

endmodule

// File: tb/tb_seq_nr_divider.sv
// Directed and exhaustive checks of seq_nr_divider at WIDTH=4 against
// hand-computed values and a truncating-division reference model.
module tb_seq_nr_divider;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic signed [3:0] dividend;
    logic signed [3:0] divisor;
    logic signed [3:0] quotient;
    logic signed [3:0] remainder;
    logic              busy;
    logic              done;
    logic              div_by_zero;
    logic              overflow;

    int tests = 0;
    int fails = 0;

    seq_nr_divider #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns edges from the accepting edge (counted as 1) to first done, and busy cycles seen.
    task automatic run_op(input logic signed [3:0] a, input logic signed [3:0] b,
                          output int lat, output int bcnt);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        bcnt  = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic check_res(input string tag, input int eq, input int er, input int ez, input int eo);
        chk({tag, " q"}, quotient, eq);
        chk({tag, " r"}, remainder, er);
        chk({tag, " dz"}, div_by_zero, ez);
        chk({tag, " ovf"}, overflow, eo);
    endtask

    initial begin
        int lat;
        int bcnt;
        int seen;
        int mq;
        int mr;
        int mz;
        int mo;
        logic signed [3:0] va;
        logic signed [3:0] vb;
        logic [31:0] tmp;
        logic signed [3:0] eq4;
        logic signed [3:0] er4;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        rst = 1'b0;
        check_res("reset", 0, 0, 0, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);

        run_op(4'sd7, 4'sd2, lat, bcnt);
        chk("7/2 latency", lat, 6);
        chk("7/2 busy cycles", bcnt, 5);
        check_res("7/2", 3, 1, 0, 0);
        tick();
        chk("7/2 done pulse", done, 0);
        tick();
        chk("7/2 hold q", quotient, 3);
        chk("7/2 hold r", remainder, 1);

        run_op(-4'sd7, 4'sd2, lat, bcnt);
        check_res("-7/2", -3, -1, 0, 0);
        run_op(4'sd7, -4'sd2, lat, bcnt);
        check_res("7/-2", -3, 1, 0, 0);
        run_op(-4'sd7, -4'sd2, lat, bcnt);
        check_res("-7/-2", 3, -1, 0, 0);
        run_op(-4'sd8, -4'sd1, lat, bcnt);
        chk("-8/-1 latency", lat, 6);
        check_res("-8/-1", -8, 0, 0, 1);
        run_op(-4'sd8, 4'sd1, lat, bcnt);
        check_res("-8/1", -8, 0, 0, 0);
        run_op(4'sd5, 4'sd0, lat, bcnt);
        chk("5/0 latency", lat, 6);
        check_res("5/0", -1, 5, 1, 0);

        // Start pulsed mid-calculation with different operands must be ignored.
        dividend = 4'sd7;
        divisor  = 4'sd2;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dividend = 4'sd3;
        divisor  = 4'sd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 3;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        chk("ignore latency", lat, 6);
        check_res("ignore", 3, 1, 0, 0);

        // Back-to-back start issued in the DONE cycle.
        dividend = -4'sd5;
        divisor  = 4'sd2;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b done drop", done, 0);
        chk("b2b busy rise", busy, 1);
        lat = 1;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        chk("b2b latency", lat, 6);
        check_res("b2b", -2, -1, 0, 0);

        // Reset in the second CALC cycle aborts with no done pulse.
        dividend = 4'sd7;
        divisor  = -4'sd2;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_res("midrst", 0, 0, 0, 0);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) seen = 1;
            tick();
        end
        chk("midrst no done", seen, 0);

        for (int a = -8; a < 8; a++) begin
            for (int b = -8; b < 8; b++) begin
                tmp = a;
                va  = tmp[3:0];
                tmp = b;
                vb  = tmp[3:0];
                mz  = 0;
                mo  = 0;
                if (b == 0) begin
                    mq = -1;
                    mr = a;
                    mz = 1;
                end else if (a == -8 && b == -1) begin
                    mq = -8;
                    mr = 0;
                    mo = 1;
                end else begin
                    mq = a / b;
                    mr = a % b;
                end
                tmp = mq;
                eq4 = tmp[3:0];
                tmp = mr;
                er4 = tmp[3:0];
                run_op(va, vb, lat, bcnt);
                chk($sformatf("sweep %0d/%0d lat", a, b), lat, 6);
                check_res($sformatf("sweep %0d/%0d", a, b), eq4, er4, mz, mo);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
